// File: rtl/ham8b_encoder_tx_pkg.sv
// ham8b_encoder_tx_pkg
// Shared definitions for the 8-bit Hamming link: transmitter FSM state
// encodings, frame size and the parity bit positions. The 12-bit corrector
// imports the same package so both sides agree on the codeword layout.
// No ports.
package ham8b_encoder_tx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } state_t;

  localparam int FRAME_DATA_BITS = 12;

  // Parity positions (1-based codeword positions).
  localparam int P1_POS = 1;
  localparam int P2_POS = 2;
  localparam int P4_POS = 4;
  localparam int P8_POS = 8;

  // Position p (1..12) lives at code[12-p], so p1 is the MSB.
  function automatic int code_idx(input int p);
    return FRAME_DATA_BITS - p;
  endfunction

endpackage

// File: rtl/ham8b_encoder_tx_encode.sv
// ham8b_encode
// Purely combinational Hamming(12,8) encoder with even parity.
// Data bits data[7]..data[0] occupy positions 3,5,6,7,9,10,11,12.
// Parity P_k (at position 2^k) is the XOR of the data bits whose
// position index has bit k set.
// Ports:
//   i_data [7:0]  byte to encode
//   o_code [11:0] codeword, position p at o_code[12-p]
module ham8b_encode
  import ham8b_encoder_tx_pkg::*;
(
  input  logic [7:0]  i_data,
  output logic [11:0] o_code
);

  always_comb begin
    logic [11:0] v_code;
    logic        v_par;
    v_code = '0;
    v_code[code_idx(3)]  = i_data[7];
    v_code[code_idx(5)]  = i_data[6];
    v_code[code_idx(6)]  = i_data[5];
    v_code[code_idx(7)]  = i_data[4];
    v_code[code_idx(9)]  = i_data[3];
    v_code[code_idx(10)] = i_data[2];
    v_code[code_idx(11)] = i_data[1];
    v_code[code_idx(12)] = i_data[0];
    for (int k = 0; k < 4; k++) begin
      v_par = 1'b0;
      for (int p = 1; p <= FRAME_DATA_BITS; p++) begin
        // The only power-of-two position with bit k set is 2^k itself,
        // so excluding it leaves exactly the covered data bits.
        if (((p >> k) & 1) == 1 && p != (1 << k))
          v_par = v_par ^ v_code[code_idx(p)];
      end
      v_code[code_idx(1 << k)] = v_par;
    end
    o_code = v_code;
  end

endmodule

// File: rtl/ham8b_encoder_tx.sv
// ham8b_encoder_tx
// Hamming(12,8) encoder and serial transmitter. Accepts one byte per
// handshake, encodes it and sends a frame: start bit (0), 12 code bits
// MSB first, stop bit (1); each bit lasts CLKS_PER_BIT cycles.
//
// Handshake: a byte is taken on a rising clk edge where i_data_valid and
// o_data_ready are both high. o_data_ready is high only while idle; valid
// seen at any other time is ignored and nothing is buffered.
//
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   i_data_in      byte to encode
//   i_data_valid   source has a byte
//   o_data_ready   idle, can accept a byte (registered, 0 in reset)
//   o_code_out     codeword of last accepted byte, held until next accept
//   o_tx           serial line, idles high
//   o_busy         frame in progress
//   o_done         one-cycle pulse after the stop bit completes
//   o_state        current FSM state
module ham8b_encoder_tx
  import ham8b_encoder_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  i_data_in,
  input  logic        i_data_valid,
  output logic        o_data_ready,
  output logic [11:0] o_code_out,
  output logic        o_tx,
  output logic        o_busy,
  output logic        o_done,
  output state_t      o_state
);

  localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BAUD_W-1:0] BAUD_MAX = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [3:0]        BIT_MAX  = 4'(FRAME_DATA_BITS - 1);

  state_t            r_state;
  state_t            w_next;
  logic [BAUD_W-1:0] r_baud;
  logic [3:0]        r_bit_cnt;
  logic [11:0]       r_shift;
  logic [11:0]       r_code;
  logic              r_ready;
  logic              r_done;
  logic [11:0]       w_enc;
  logic              w_baud_last;
  logic              w_accept;

  ham8b_encode u_encode (
    .i_data (i_data_in),
    .o_code (w_enc)
  );

  assign w_baud_last = (r_baud == BAUD_MAX);
  assign w_accept    = (r_state == ST_IDLE) && i_data_valid && r_ready;

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:  if (w_accept) w_next = ST_START;
      ST_START: if (w_baud_last) w_next = ST_DATA;
      ST_DATA:  if (w_baud_last && r_bit_cnt == BIT_MAX) w_next = ST_STOP;
      ST_STOP:  if (w_baud_last) w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_baud    <= '0;
      r_bit_cnt <= '0;
      r_shift   <= '0;
      r_code    <= '0;
      r_ready   <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      // Baud counter runs only inside a frame and wraps at each bit boundary.
      if (r_state == ST_IDLE || w_baud_last) r_baud <= '0;
      else                                   r_baud <= r_baud + 1'b1;

      if (r_state != ST_DATA)
        r_bit_cnt <= '0;
      else if (w_baud_last)
        r_bit_cnt <= (r_bit_cnt == BIT_MAX) ? 4'd0 : r_bit_cnt + 4'd1;

      if (w_accept) begin
        r_shift <= w_enc;
        r_code  <= w_enc;
      end else if (r_state == ST_DATA && w_baud_last) begin
        r_shift <= {r_shift[10:0], 1'b0};
      end

      // Ready follows the state we are about to enter, so it is high in the
      // done cycle and a back-to-back byte can be taken there.
      r_ready <= (w_next == ST_IDLE);
      r_done  <= (r_state == ST_STOP) && (w_next == ST_IDLE);
    end
  end

  // Line level decoded from registered state, so reset forces it high at once.
  always_comb begin
    o_tx = 1'b1;
    case (r_state)
      ST_START: o_tx = 1'b0;
      ST_DATA:  o_tx = r_shift[11];
      default:  o_tx = 1'b1;
    endcase
  end

  assign o_busy       = (r_state != ST_IDLE);
  assign o_data_ready = r_ready;
  assign o_code_out   = r_code;
  assign o_done       = r_done;
  assign o_state      = r_state;

endmodule
